dmux16_router: RTL and testbench
================================

// Module: dmux16_router
// PURPOSE
//  Demultiplexing counterpart of the 16-bit word mux: routes one input word stream to one of
//  NUM_OUT output channels selected by in_sel, with valid/ready flow control on every side.
//  Each channel owns a one-entry holding register, so a stalled channel does not block
//  words already delivered to other channels.
//  Sits between the CPU data-out bus and memory-mapped sinks (RAM bank, screen, port regs).
// PARAMETERS
//  WIDTH    16  data word width in bits
//  NUM_OUT  4   number of output channels, power of two, 2..16
//  SELW     2   in_sel width = log2(NUM_OUT)
// PORTS
//  clk        in   1               single clock, all state on rising edge
//  rst_n      in   1               synchronous reset, active low
//  in_valid   in   1               input word present
//  in_ready   out  1               router accepts the word this cycle
//  in_sel     in   SELW            destination channel index
//  in_data    in   WIDTH           input word
//  out_valid  out  NUM_OUT         per-channel word present
//  out_ready  in   NUM_OUT         per-channel consumer accepts
//  out_data   out  NUM_OUT*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  acc_count  out  16              words accepted since reset, wraps 0xFFFF->0x0000
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, acc_count=0; in_ready is
//    combinational and reads 1 from the first cycle after reset.
//  - Reset mid-operation discards all held words; no partial state survives.
//  - Accept: acc = in_valid & in_ready. in_ready = ~out_valid[in_sel] | out_ready[in_sel].
//    in_ready depends only on the selected channel; there is no combinational in_valid->in_ready path.
//  - Pop: channel i pops when out_valid[i] & out_ready[i].
//  - Per channel i, next state:
//      acc & in_sel==i           -> out_valid[i]=1, out_data[i]=in_data (refill, even if popping)
//      else pop                  -> out_valid[i]=0, out_data[i] held (value don't-care)
//      else                      -> hold
//  - Latency: word accepted at edge N is visible on out_data/out_valid after edge N.
//    Full throughput: 1 word/cycle to one channel if its consumer holds out_ready=1.
//  - Full channel with out_ready=0: in_ready=0 for words addressed to it; the producer must
//    hold in_valid/in_sel/in_data stable until accepted.
//  - Other channels keep popping independently while one is stalled.
//  - out_valid[i] never drops without a pop; out_data[i] is stable while out_valid[i]=1
//    and unpopped.
//  - acc_count increments by 1 on each acc; 16-bit unsigned wrap, no saturation.
//  - Simultaneous pop on channel j and accept to channel k!=j: both take effect the same cycle.
// STRUCTURE
//  - Shared include: WORD_W=16 and channel-index localparams, reused by the mux side.
//  - Sub-module dmux_slot (WIDTH): one holding register with load/pop/valid, instanced
//    NUM_OUT times in a generate loop. The top level has the in_sel decode, in_ready mux
//    and acc_count.
//  - No FSM beyond per-slot valid bits; no latches; fully synchronous.
// TESTING
//  1 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0000, acc_count=0;
//    in_ready=1 after release.
//  2 Single route: sel=2, data=0xBEEF, out_ready=0000 -> next cycle out_valid=0100,
//    ch2=0xBEEF, acc_count=1.
//  3 Backpressure: ch2 full, out_ready[2]=0, sel=2 data=0x1234 -> in_ready=0 for 5 cycles,
//    ch2 stays 0xBEEF; raise out_ready[2] -> same-cycle pop+refill, ch2=0x1234.
//  4 Isolation: ch2 stalled full; stream 0x0001..0x0004 to ch0 with out_ready[0]=1 ->
//    4 words/4 cycles on ch0 in order, ch2 unchanged.
//  5 Wrap: preload acc_count to 0xFFFF by 65535 accepts, one more -> acc_count=0x0000.
//  6 Mid-op reset: all channels full, assert rst_n=0 one cycle -> out_valid=0000,
//    acc_count=0, no spurious pops afterward.

Source files
------------

// File: rtl/dmux16_router_pkg.sv
// Shared word width and channel map for the 16-bit router family.
// Both the mux side and the demux side use these definitions.
package dmux16_router_pkg;

    localparam int WORD_W = 16;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int ACC_W  = 16;

    // Sink assignment on the CPU data-out bus
    localparam int CH_RAM    = 0;
    localparam int CH_VRAM   = 1;
    localparam int CH_SCREEN = 2;
    localparam int CH_PORT   = 3;

endpackage

// File: rtl/dmux16_router_if.sv
// Word stream into the router and the per-channel output streams.
// Every stream uses valid/ready flow control.
interface dmux16_router_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 4,
    parameter int SELW    = 2
);

    logic                     in_valid;
    logic                     in_ready;
    logic [SELW-1:0]          in_sel;
    logic [WIDTH-1:0]         in_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;

    // Producer and consumers of the router
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/dmux16_router_slot.sv
// One-entry holding register for a single output channel.
// A load takes priority over a pop, so a word can be popped and replaced in the same cycle.
module dmux_slot
    import dmux16_router_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dmux16_router.sv
// Routes one word stream to NUM_OUT channels by in_sel, with one holding slot per channel.
// A stalled channel only stalls words addressed to it.
module dmux16_router
    import dmux16_router_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int NUM_OUT = NUM_CH,
    parameter int SELW    = SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    dmux16_router_if.slave   bus,
    output logic [ACC_W-1:0] acc_count
);

    logic                 in_ready;
    logic                 acc;
    logic [NUM_OUT-1:0]   slot_valid;
    logic [NUM_OUT-1:0]   load;
    logic [NUM_OUT-1:0]   pop;
    logic [WIDTH-1:0]     slot_data [NUM_OUT];
    logic [ACC_W-1:0]     acc_count_q, acc_count_d;

    // Ready looks only at the addressed slot, never at in_valid
    assign in_ready     = ~slot_valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    assign acc          = bus.in_valid & in_ready;
    assign bus.in_ready = in_ready;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
        assign load[i] = acc & (bus.in_sel == SELW'(i));
        assign pop[i]  = slot_valid[i] & bus.out_ready[i];

        dmux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[i]),
            .pop_i   (pop[i]),
            .data_i  (bus.in_data),
            .valid_o (slot_valid[i]),
            .data_o  (slot_data[i])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            bus.out_data[i*WIDTH +: WIDTH] = slot_data[i];
        end
    end

    assign bus.out_valid = slot_valid;

    always_comb begin
        acc_count_d = acc_count_q;
        if (acc) begin
            acc_count_d = acc_count_q + ACC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_count_q <= '0;
        end else begin
            acc_count_q <= acc_count_d;
        end
    end

    assign acc_count = acc_count_q;

endmodule

// File: tb/tb_dmux16_router.sv
// Bench for dmux16_router: directed scenarios plus randomized traffic against a
// channel-level reference model (per-channel full flag and word, accepted-word total).
module tb_dmux16_router;
    import dmux16_router_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] acc_count;

    dmux16_router_if #(.WIDTH(16), .NUM_OUT(4), .SELW(2)) bus ();

    dmux16_router dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .acc_count (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit          mv [4];
    logic [15:0] md [4];
    logic [15:0] mcnt;

    function automatic logic [3:0] exp_valid();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = mv[i];
        return r;
    endfunction

    function automatic logic [63:0] exp_mask();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = mv[i] ? 16'hFFFF : 16'h0000;
        return r;
    endfunction

    function automatic logic [63:0] exp_data();
        logic [63:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = md[i];
        return r;
    endfunction

    function automatic bit exp_ready();
        int s;
        s = int'(bus.in_sel);
        return !mv[s] || bus.out_ready[s];
    endfunction

    // Advance one clock; the model applies the channel rules to the inputs present at the edge
    task automatic cycle();
        bit          nv [4];
        logic [15:0] nd [4];
        logic [15:0] nc;
        bit          a;
        int          s;
        s = int'(bus.in_sel);
        a = bus.in_valid && exp_ready();
        nc = mcnt;
        for (int i = 0; i < 4; i++) begin
            nv[i] = mv[i];
            nd[i] = md[i];
        end
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                nv[i] = 1'b0;
                nd[i] = 16'h0000;
            end
            nc = 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (a && s == i) begin
                    nv[i] = 1'b1;
                    nd[i] = bus.in_data;
                end else if (mv[i] && bus.out_ready[i]) begin
                    nv[i] = 1'b0;
                end
            end
            if (a) nc = mcnt + 16'd1;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
        mcnt = nc;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 2'd1;
        bus.in_data  = 16'hA5A5;
        bus.out_ready = 4'b0000;
        cycle();
        cycle();
        n_checks++;
        if (bus.out_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h want 0", bus.out_data);
        end
        n_checks++;
        if (acc_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_acc_count: got %h want 0000", acc_count);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single_route();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'(CH_SCREEN);
        bus.in_data   = 16'hBEEF;
        cycle();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 4'b0100) begin
            n_fail++;
            $display("FAIL route_out_valid: got %b want 0100", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data[CH_SCREEN*16 +: 16] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL route_ch2_data: got %h want beef", bus.out_data[CH_SCREEN*16 +: 16]);
        end
        n_checks++;
        if (acc_count !== 16'd1) begin
            n_fail++;
            $display("FAIL route_acc_count: got %0d want 1", acc_count);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'(CH_SCREEN);
        bus.in_data   = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready cyc%0d: got %b want 0", k, bus.in_ready);
            end
            cycle();
            n_checks++;
            if (bus.out_data[CH_SCREEN*16 +: 16] !== 16'hBEEF || bus.out_valid[CH_SCREEN] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_ch2_hold cyc%0d: got v=%b %h want v=1 beef", k,
                         bus.out_valid[CH_SCREEN], bus.out_data[CH_SCREEN*16 +: 16]);
            end
        end
        bus.out_ready[CH_SCREEN] = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", bus.in_ready);
        end
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        n_checks++;
        if (bus.out_valid !== 4'b0100 || bus.out_data[CH_SCREEN*16 +: 16] !== 16'h1234) begin
            n_fail++;
            $display("FAIL bp_refill: got v=%b %h want v=0100 1234", bus.out_valid,
                     bus.out_data[CH_SCREEN*16 +: 16]);
        end
        n_checks++;
        if (acc_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_acc_count: got %0d want 2", acc_count);
        end
    endtask

    task automatic test_isolation();
        bus.out_ready = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(CH_RAM);
            bus.in_data  = 16'(k);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL iso_in_ready word%0d: got %b want 1", k, bus.in_ready);
            end
            cycle();
            n_checks++;
            if (bus.out_valid[CH_RAM] !== 1'b1 || bus.out_data[CH_RAM*16 +: 16] !== 16'(k)) begin
                n_fail++;
                $display("FAIL iso_ch0 word%0d: got v=%b %h want v=1 %h", k,
                         bus.out_valid[CH_RAM], bus.out_data[CH_RAM*16 +: 16], 16'(k));
            end
            n_checks++;
            if (bus.out_valid[CH_SCREEN] !== 1'b1 || bus.out_data[CH_SCREEN*16 +: 16] !== 16'h1234) begin
                n_fail++;
                $display("FAIL iso_ch2_stable word%0d: got v=%b %h want v=1 1234", k,
                         bus.out_valid[CH_SCREEN], bus.out_data[CH_SCREEN*16 +: 16]);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
        n_checks++;
        if (bus.out_valid !== 4'b0100 || acc_count !== 16'd6) begin
            n_fail++;
            $display("FAIL iso_drain: got v=%b cnt=%0d want v=0100 cnt=6", bus.out_valid, acc_count);
        end
    endtask

    task automatic test_random();
        bit held;
        held = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!held) begin
                bus.in_valid = 1'($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom);
                bus.in_data  = 16'($urandom);
            end
            bus.out_ready = 4'($urandom);
            #1;
            n_checks++;
            if (bus.in_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rnd_in_ready cyc%0d: got %b want %b", k, bus.in_ready, exp_ready());
            end
            held = bus.in_valid && !exp_ready();
            cycle();
            n_checks++;
            if (bus.out_valid !== exp_valid() || (bus.out_data & exp_mask()) !== (exp_data() & exp_mask())
                || acc_count !== mcnt) begin
                n_fail++;
                $display("FAIL rnd_state cyc%0d: got v=%b d=%h c=%h want v=%b d=%h c=%h", k,
                         bus.out_valid, bus.out_data & exp_mask(), acc_count,
                         exp_valid(), exp_data() & exp_mask(), mcnt);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_wrap();
        int iter;
        iter = 0;
        bus.out_ready = 4'b0010;
        bus.in_valid  = 1'b1;
        bus.in_sel    = 2'(CH_VRAM);
        while (mcnt != 16'hFFFF && iter < 70000) begin
            bus.in_data = 16'($urandom);
            cycle();
            iter++;
        end
        n_checks++;
        if (acc_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload: got %h want ffff", acc_count);
        end
        bus.in_data = 16'hC0DE;
        cycle();
        bus.in_valid = 1'b0;
        n_checks++;
        if (acc_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_rollover: got %h want 0000", acc_count);
        end
        n_checks++;
        if (bus.out_valid[CH_VRAM] !== 1'b1 || bus.out_data[CH_VRAM*16 +: 16] !== 16'hC0DE) begin
            n_fail++;
            $display("FAIL wrap_ch1_data: got v=%b %h want v=1 c0de", bus.out_valid[CH_VRAM],
                     bus.out_data[CH_VRAM*16 +: 16]);
        end
    endtask

    task automatic test_midop_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        cycle();
        bus.out_ready = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = 2'(s);
            bus.in_data  = 16'($urandom) | 16'h0001;
            cycle();
        end
        n_checks++;
        if (bus.out_valid !== 4'b1111 || (bus.out_data & exp_mask()) !== exp_data()) begin
            n_fail++;
            $display("FAIL mrst_fill: got v=%b d=%h want v=1111 d=%h", bus.out_valid,
                     bus.out_data, exp_data());
        end
        rst_n = 1'b0;
        cycle();
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        n_checks++;
        if (bus.out_valid !== 4'b0000 || acc_count !== 16'h0000 || bus.out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL mrst_cleared: got v=%b c=%h d=%h want v=0000 c=0000 d=0",
                     bus.out_valid, acc_count, bus.out_data);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (bus.out_valid !== 4'b0000 || acc_count !== 16'h0000 || bus.out_valid !== exp_valid()) begin
                n_fail++;
                $display("FAIL mrst_quiet cyc%0d: got v=%b c=%h want v=0000 c=0000", k,
                         bus.out_valid, acc_count);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 16'h0000;
        end
        mcnt = 16'h0000;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        @(negedge clk);
        test_reset();
        test_single_route();
        test_backpressure();
        test_isolation();
        test_random();
        test_wrap();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
